mulaw_enc_arb: RTL and testbench

MULAW_ENC_ARB -- requirements
Module: mulaw_enc_arb

---
 rtl/mulaw_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/mulaw_enc_arb.sv | 144 ++++++++++++++
 tb/tb_mulaw_enc_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mulaw_pkg.sv
// Shared types for the mu-law encoder front-end arbiter: encoder
// configuration record, per-sample tag and the control FSM states.
package mulaw_pkg;

    // Data widths of one mu-law configuration.
    typedef struct packed {
        int P_DECODED_DW;
        int P_ENCODED_DW;
    } mulaw_cfg_t;

    // 16-bit linear samples in, 11-bit codes out.
    localparam mulaw_cfg_t MU_LAW_16_11 = '{P_DECODED_DW: 16, P_ENCODED_DW: 11};

    // Channel field sized for the largest supported requester count (16).
    localparam int TAG_CH_W = 4;

    // Travels alongside each sample so the result can be routed back.
    typedef struct packed {
        logic                valid;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the search starts one past the last winner and
// wraps modulo N, so every requester is served within N grants.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt
);

    localparam int IW = $clog2(N);

    // (base + off) mod N for base < N and off <= N; never yields an index >= N.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IW'(sum);
    endfunction

    logic [IW-1:0] idx;
    logic          found;

    // First requesting channel at or after last+1 wins the one-hot grant.
    always_comb begin
        // NOTE: every variable gets a default before the loop; a path that left one unassigned would infer a latch.
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = wrap_add(last, off);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mulaw_enc_arb.sv
// Shares one external mu-law encoder between N_CH requesters. Accepted
// samples are tagged with their channel; the tag rides a shift register
// matched to the encoder latency so each code is returned with its owner.
module mulaw_enc_arb
    import mulaw_pkg::*;
#(
    parameter mulaw_cfg_t cfg_t      = MU_LAW_16_11,
    parameter int         N_CH       = 4,
    parameter int         PIPE_DELAY = 6,
    localparam int        DDW        = cfg_t.P_DECODED_DW,
    localparam int        EDW        = cfg_t.P_ENCODED_DW,
    localparam int        CHW        = $clog2(N_CH)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [N_CH-1:0]     i_req_valid,
    input  logic [N_CH*DDW-1:0] i_req_dt,
    output logic [N_CH-1:0]     o_req_ready,
    output logic [DDW-1:0]      o_enc_dt,
    output logic                o_enc_enable,
    input  logic [EDW-1:0]      i_enc_dt,
    input  logic                i_enc_enable,
    output logic                o_rsp_valid,
    output logic [CHW-1:0]      o_rsp_ch,
    output logic [EDW-1:0]      o_rsp_dt,
    output logic                o_busy,
    output logic                o_err
);

    localparam int HW = $clog2(PIPE_DELAY + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CHW-1:0]  last_grant;
    logic [CHW-1:0]  grant_idx;
    logic [N_CH-1:0] gnt;
    logic            accept;
    logic [CHW-1:0]  enc_ch;
    tag_t            tag_pipe [PIPE_DELAY];
    tag_t            tap;
    logic            tap_ch_unused;
    logic [HW-1:0]   hold_cnt;
    logic            masked;
    logic            pipe_busy;

    rr_arbiter #(.N(N_CH)) u_rr (
        .req  (i_req_valid),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign o_req_ready = (state == ST_RUN && i_en) ? gnt : '0;
    assign accept      = |(o_req_ready & i_req_valid);
    assign o_busy      = (state != ST_IDLE);
    assign tap         = tag_pipe[PIPE_DELAY-1];
    // Channel bits above CHW are always zero; folding them keeps them read.
    assign tap_ch_unused = ^tap.ch;
    // Encoder output is ignored until anything issued before reset has flushed out.
    assign masked      = (hold_cnt != '0);

    // Binary index of the one-hot grant.
    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt[k]) grant_idx = CHW'(k);
        end
    end

    // A sample is still travelling if the issue slot or any tag slot is valid.
    always_comb begin
        pipe_busy = o_enc_enable;
        for (int i = 0; i < PIPE_DELAY; i++) begin
            pipe_busy = pipe_busy | tag_pipe[i].valid;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: drain lets in-flight samples finish after i_en drops.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_en) state_nxt = ST_RUN;
            ST_RUN:   if (!i_en) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (i_en)            state_nxt = ST_RUN;
                else if (!pipe_busy) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Issue register: hand the accepted sample to the encoder, remember its owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_enc_enable <= 1'b0;
            o_enc_dt     <= '0;
            enc_ch       <= '0;
            last_grant   <= CHW'(N_CH - 1);
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values regardless of statement order.
            o_enc_enable <= accept;
            if (accept) begin
                o_enc_dt   <= i_req_dt[int'(grant_idx)*DDW +: DDW];
                enc_ch     <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // Tag shift register; its tap lines up with the encoder's o_enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: this small register array is reset on purpose: a stale valid bit would report a phantom result.
            for (int i = 0; i < PIPE_DELAY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: o_enc_enable, ch: TAG_CH_W'(enc_ch)};
            for (int i = 1; i < PIPE_DELAY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Response registers, post-reset mask and sticky alignment error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt    <= HW'(PIPE_DELAY);
            o_rsp_valid <= 1'b0;
            o_rsp_ch    <= '0;
            o_rsp_dt    <= '0;
            o_err       <= 1'b0;
        end else begin
            if (masked) hold_cnt <= hold_cnt - HW'(1);
            o_rsp_valid <= i_enc_enable & tap.valid & ~masked;
            o_rsp_ch    <= tap.ch[CHW-1:0];
            o_rsp_dt    <= i_enc_dt;
            if (!masked && (i_enc_enable != tap.valid)) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mulaw_enc_arb.sv
// Bench for mulaw_enc_arb wired to a behavioural mu-law encoder model.
// Stimulus pushes expected grants/results into queues; monitors compare.
module tb_mulaw_enc_arb;
    import mulaw_pkg::*;

    localparam int N_CH = 4;
    localparam int PD   = 6;
    localparam int DDW  = 16;
    localparam int EDW  = 11;
    localparam int LAT  = PD + 2;
    localparam int NV   = 8;

    typedef struct {
        int             ch;
        logic [EDW-1:0] dt;
        int             cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en;
    logic [N_CH-1:0]     req_valid;
    logic [N_CH*DDW-1:0] req_dt;
    logic [N_CH-1:0]     req_ready;
    logic [DDW-1:0]      enc_dt_o;
    logic                enc_enable_o;
    logic [EDW-1:0]      enc_dt_i;
    logic                enc_enable_i;
    logic                rsp_valid;
    logic [1:0]          rsp_ch;
    logic [EDW-1:0]      rsp_dt;
    logic                busy;
    logic                err;
    logic                force_off;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t rsp_q[$];
    int   gnt_q[$];

    logic [DDW-1:0] vecs [NV] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                                  16'h1234, 16'hFFFF, 16'h0040, 16'hC350};

    logic [EDW-1:0] enc_dt_pipe [PD];
    logic           enc_en_pipe [PD];

    mulaw_enc_arb #(.N_CH(N_CH), .PIPE_DELAY(PD)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_req_valid  (req_valid),
        .i_req_dt     (req_dt),
        .o_req_ready  (req_ready),
        .o_enc_dt     (enc_dt_o),
        .o_enc_enable (enc_enable_o),
        .i_enc_dt     (enc_dt_i),
        .i_enc_enable (enc_enable_i),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_ch     (rsp_ch),
        .o_rsp_dt     (rsp_dt),
        .o_busy       (busy),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference segment encoder: sign, 4-bit exponent, 6-bit mantissa, inverted.
    function automatic logic [EDW-1:0] enc_ref(input logic [DDW-1:0] x);
        logic        s;
        logic [14:0] m;
        logic [3:0]  e;
        logic [5:0]  f;
        s = x[15];
        m = s ? ~x[14:0] : x[14:0];
        e = 4'd0;
        f = m[5:0];
        for (int p = 6; p <= 14; p++) begin
            if (m[p]) begin
                e = 4'(p - 5);
                f = m[p-1 -: 6];
            end
        end
        return ~{s, e, f};
    endfunction

    // Encoder model: PD-cycle pipeline, deliberately not reset.
    initial begin
        for (int i = 0; i < PD; i++) begin
            enc_dt_pipe[i] = '0;
            enc_en_pipe[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        enc_dt_pipe[0] <= enc_ref(enc_dt_o);
        enc_en_pipe[0] <= enc_enable_o;
        for (int i = 1; i < PD; i++) begin
            enc_dt_pipe[i] <= enc_dt_pipe[i-1];
            enc_en_pipe[i] <= enc_en_pipe[i-1];
        end
    end

    assign enc_dt_i     = enc_dt_pipe[PD-1];
    assign enc_enable_i = enc_en_pipe[PD-1] & ~force_off;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string msg);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Grant monitor: ready must be one-hot within the requesters; accepts follow the expected order.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            check("ready_onehot", 32'($countones(req_ready)), 32'd1);
            check("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
        end
        if (|(req_ready & req_valid)) begin
            int c;
            c = 0;
            for (int k = N_CH - 1; k >= 0; k--) if (req_ready[k] & req_valid[k]) c = k;
            if (gnt_q.size() == 0) flag("unexpected_accept", $sformatf("channel %0d accepted", c));
            else check("grant_ch", 32'(c), 32'(gnt_q.pop_front()));
        end
    end

    // Result monitor: channel, code and arrival cycle against the scoreboard.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                flag("unexpected_rsp", $sformatf("ch %0d dt 0x%0h", rsp_ch, rsp_dt));
            end else begin
                exp_t e;
                e = rsp_q.pop_front();
                check("rsp_ch", 32'(rsp_ch), 32'(e.ch));
                check("rsp_dt", 32'(rsp_dt), 32'(e.dt));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int target);
        while (cyc < target) tick();
        @(negedge clk);
    endtask

    // Present one cycle of requests; exp_ch < 0 means no accept is expected.
    task automatic drive(input logic [N_CH-1:0] valid, input int j, input int exp_ch, input bit exp_rsp);
        req_valid = valid;
        for (int k = 0; k < N_CH; k++) req_dt[k*DDW +: DDW] = vecs[(j + k) % NV];
        if (exp_ch >= 0) begin
            gnt_q.push_back(exp_ch);
            if (exp_rsp) rsp_q.push_back('{ch: exp_ch, dt: enc_ref(vecs[(j + exp_ch) % NV]), cyc: cyc + LAT});
        end
        tick();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},       32'(busy),         32'd0);
        check({tag, "_ready"},      32'(req_ready),    32'd0);
        check({tag, "_enc_enable"}, 32'(enc_enable_o), 32'd0);
        check({tag, "_enc_dt"},     32'(enc_dt_o),     32'd0);
        check({tag, "_rsp_valid"},  32'(rsp_valid),    32'd0);
        check({tag, "_rsp_ch"},     32'(rsp_ch),       32'd0);
        check({tag, "_rsp_dt"},     32'(rsp_dt),       32'd0);
        check({tag, "_err"},        32'(err),          32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int l;
        int s4[5];
        en        = 1'b0;
        req_valid = '0;
        req_dt    = '0;
        force_off = 1'b0;
        s4        = '{3, 0, 1, 2, 3};

        // Reset state.
        #12;
        check_cleared("reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (LAT + 2) tick();

        // All four channels requesting: grants 0,1,2,3,0,1,2,3, one result per cycle.
        en = 1'b1;
        drive('0, 0, -1, 1'b0);
        for (int j = 0; j < 8; j++) drive(4'hF, j, j % 4, 1'b1);
        drive('0, 0, -1, 1'b0);
        repeat (LAT) tick();

        // Only ch1 and ch3 requesting: grants alternate 1,3,1,3.
        for (int j = 0; j < 4; j++) drive(4'b1010, j, (j % 2 == 0) ? 1 : 3, 1'b1);
        drive('0, 0, -1, 1'b0);
        repeat (LAT) tick();

        // Single ch2 request of 16'h0000: result exactly LAT cycles after accept.
        a = cyc;
        drive(4'b0100, 6, 2, 1'b1);
        drive('0, 0, -1, 1'b0);
        wait_neg(a + LAT - 1);
        check("s1_early_valid", 32'(rsp_valid), 32'd0);
        wait_neg(a + LAT);
        check("s1_valid", 32'(rsp_valid), 32'd1);
        check("s1_ch",    32'(rsp_ch),    32'd2);
        check("s1_dt",    32'(rsp_dt),    32'h7FF);
        tick();

        // Drop i_en with five samples in flight; requests stay up but nothing is accepted.
        l = cyc + 4;
        for (int j = 0; j < 5; j++) drive(4'hF, j, s4[j], 1'b1);
        en = 1'b0;
        repeat (3) tick();
        req_valid = '0;
        wait_neg(l + LAT);
        check("s4_last_rsp",  32'(rsp_valid), 32'd1);
        check("s4_busy_high", 32'(busy),      32'd1);
        wait_neg(l + LAT + 1);
        check("s4_busy_low",  32'(busy),      32'd0);
        tick();

        // Suppress the encoder's enable while a tag is at the tap: sticky error.
        en = 1'b1;
        drive('0, 0, -1, 1'b0);
        a = cyc;
        drive(4'b0001, 3, 0, 1'b0);
        drive('0, 0, -1, 1'b0);
        while (cyc < a + PD + 1) tick();
        force_off = 1'b1;
        @(negedge clk);
        check("s5_err_before", 32'(err), 32'd0);
        tick();
        force_off = 1'b0;
        @(negedge clk);
        check("s5_err_set",    32'(err),       32'd1);
        check("s5_no_rsp",     32'(rsp_valid), 32'd0);
        repeat (5) tick();
        check("s5_err_held",   32'(err),       32'd1);

        // Reset pulse mid-stream: in-flight results dropped, masked, ch0 first afterwards.
        for (int j = 0; j < 4; j++) drive(4'hF, j, (j + 1) % 4, 1'b1);
        rst_n = 1'b0;
        #1;
        check_cleared("mid_reset");
        rsp_q.delete();
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("s6_no_rsp", 32'(rsp_valid), 32'd0);
            check("s6_no_err", 32'(err),       32'd0);
            tick();
        end
        drive(4'hF, 0, 0, 1'b1);
        drive(4'hF, 1, 1, 1'b1);
        drive(4'hF, 2, 2, 1'b1);
        drive('0, 0, -1, 1'b0);
        repeat (LAT + 2) tick();

        check("rsp_queue_empty",   32'(rsp_q.size()), 32'd0);
        check("grant_queue_empty", 32'(gnt_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
